// File: rtl/sdram_fifo_ctrl.sv
// rtl/sdram_fifo_ctrl.sv - write/read FIFOs and burst scheduler in front of sdram_ctrl
// Buffers camera pixels for burst writes and prefetches display pixels with burst reads.
module sdram_fifo_ctrl #(
  parameter int          FIFO_DEPTH = 1024,
  parameter logic [9:0]  BURST_LEN  = 10'd256,
  parameter logic [23:0] WR_BASE    = 24'd0,
  parameter logic [23:0] WR_END     = 24'd307200,
  parameter logic [23:0] RD_BASE    = 24'd0,
  parameter logic [23:0] RD_END     = 24'd307200
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        wr_fifo_wr_en,
  input  logic [15:0] wr_fifo_wr_data,
  output logic        wr_fifo_full,
  input  logic        rd_valid,
  input  logic        rd_fifo_rd_en,
  output logic [15:0] rd_fifo_rd_data,
  output logic        rd_fifo_empty,
  output logic        sdram_wr_req,
  input  logic        sdram_wr_ack,
  output logic [23:0] sdram_wr_addr,
  output logic [15:0] sdram_wr_data,
  output logic [9:0]  wr_burst_len,
  output logic        sdram_rd_req,
  input  logic        sdram_rd_ack,
  output logic [23:0] sdram_rd_addr,
  input  logic [15:0] sdram_rd_data,
  output logic [9:0]  rd_burst_len
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] BURST_L = LW'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [15:0]       r_wr_mem [FIFO_DEPTH];
  logic [15:0]       r_rd_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_wptr, r_wr_rptr, r_rd_wptr, r_rd_rptr;
  logic [LW-1:0]     r_wr_level, r_rd_level;
  logic              r_wr_req, r_rd_req, r_wr_ack_d, r_rd_ack_d;
  logic [23:0]       r_wr_addr, r_rd_addr;
  logic              w_wr_push, w_wr_pop, w_rd_push, w_rd_pop, w_rd_flush;
  logic              w_wr_end, w_rd_end;
  logic [23:0]       w_wr_addr_inc, w_rd_addr_inc;

  assign w_wr_push  = wr_fifo_wr_en && (r_wr_level != DEPTH_L);
  assign w_wr_pop   = sdram_wr_ack && (r_wr_level != '0);
  assign w_rd_push  = sdram_rd_ack && (r_rd_level != DEPTH_L);
  assign w_rd_pop   = rd_fifo_rd_en && (r_rd_level != '0);
  // A burst already in flight is allowed to finish before the read side is flushed.
  assign w_rd_flush = !rd_valid && (r_state != S_RD);
  assign w_wr_end   = (r_state == S_WR) && r_wr_ack_d && !sdram_wr_ack;
  assign w_rd_end   = (r_state == S_RD) && r_rd_ack_d && !sdram_rd_ack;
  assign w_wr_addr_inc = r_wr_addr + {14'd0, BURST_LEN};
  assign w_rd_addr_inc = r_rd_addr + {14'd0, BURST_LEN};

  always_ff @(posedge sys_clk) begin
    if (w_wr_push) r_wr_mem[r_wr_wptr] <= wr_fifo_wr_data;
    if (w_rd_push) r_rd_mem[r_rd_wptr] <= sdram_rd_data;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_wptr  <= '0;
      r_wr_rptr  <= '0;
      r_wr_level <= '0;
    end else begin
      if (w_wr_push) r_wr_wptr <= r_wr_wptr + 1'b1;
      if (w_wr_pop)  r_wr_rptr <= r_wr_rptr + 1'b1;
      if (w_wr_push && !w_wr_pop)      r_wr_level <= r_wr_level + 1'b1;
      else if (w_wr_pop && !w_wr_push) r_wr_level <= r_wr_level - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rd_wptr  <= '0;
      r_rd_rptr  <= '0;
      r_rd_level <= '0;
    end else if (w_rd_flush) begin
      r_rd_wptr  <= '0;
      r_rd_rptr  <= '0;
      r_rd_level <= '0;
    end else begin
      if (w_rd_push) r_rd_wptr <= r_rd_wptr + 1'b1;
      if (w_rd_pop)  r_rd_rptr <= r_rd_rptr + 1'b1;
      if (w_rd_push && !w_rd_pop)      r_rd_level <= r_rd_level + 1'b1;
      else if (w_rd_pop && !w_rd_push) r_rd_level <= r_rd_level - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (init_end && (r_wr_level >= BURST_L))
          w_state_next = S_WR;
        else if (init_end && rd_valid && ((DEPTH_L - r_rd_level) >= BURST_L))
          w_state_next = S_RD;
      end
      S_WR:    if (w_wr_end) w_state_next = S_IDLE;
      S_RD:    if (w_rd_end) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Requests rise on FSM entry and drop after the first ack cycle of the burst.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_req   <= 1'b0;
      r_rd_req   <= 1'b0;
      r_wr_ack_d <= 1'b0;
      r_rd_ack_d <= 1'b0;
      r_wr_addr  <= WR_BASE;
      r_rd_addr  <= RD_BASE;
    end else begin
      r_wr_ack_d <= sdram_wr_ack;
      r_rd_ack_d <= sdram_rd_ack;
      if (r_state == S_IDLE && w_state_next == S_WR) r_wr_req <= 1'b1;
      else if (sdram_wr_ack)                         r_wr_req <= 1'b0;
      if (r_state == S_IDLE && w_state_next == S_RD) r_rd_req <= 1'b1;
      else if (sdram_rd_ack)                         r_rd_req <= 1'b0;
      if (w_wr_end)
        r_wr_addr <= (w_wr_addr_inc >= WR_END) ? WR_BASE : w_wr_addr_inc;
      if (w_rd_flush)
        r_rd_addr <= RD_BASE;
      else if (w_rd_end)
        r_rd_addr <= (w_rd_addr_inc >= RD_END) ? RD_BASE : w_rd_addr_inc;
    end
  end

  assign wr_fifo_full    = (r_wr_level == DEPTH_L);
  assign rd_fifo_empty   = (r_rd_level == '0);
  assign sdram_wr_data   = (r_wr_level == '0) ? 16'd0 : r_wr_mem[r_wr_rptr];
  assign rd_fifo_rd_data = (r_rd_level == '0) ? 16'd0 : r_rd_mem[r_rd_rptr];
  assign sdram_wr_req    = r_wr_req;
  assign sdram_rd_req    = r_rd_req;
  assign sdram_wr_addr   = r_wr_addr;
  assign sdram_rd_addr   = r_rd_addr;
  assign wr_burst_len    = BURST_LEN;
  assign rd_burst_len    = BURST_LEN;

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// tb/tb_sdram_fifo_ctrl.sv - scoreboard bench for sdram_fifo_ctrl
// Write region is shrunk to 512 words so the address wrap is reachable quickly.
module tb_sdram_fifo_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_end = 1'b0;
  logic        wr_fifo_wr_en = 1'b0;
  logic [15:0] wr_fifo_wr_data = 16'd0;
  logic        wr_fifo_full;
  logic        rd_valid = 1'b0;
  logic        rd_fifo_rd_en = 1'b0;
  logic [15:0] rd_fifo_rd_data;
  logic        rd_fifo_empty;
  logic        sdram_wr_req;
  logic        sdram_wr_ack = 1'b0;
  logic [23:0] sdram_wr_addr;
  logic [15:0] sdram_wr_data;
  logic [9:0]  wr_burst_len;
  logic        sdram_rd_req;
  logic        sdram_rd_ack = 1'b0;
  logic [23:0] sdram_rd_addr;
  logic [15:0] sdram_rd_data = 16'd0;
  logic [9:0]  rd_burst_len;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] wr_q[$];
  logic [15:0] rd_q[$];
  logic [23:0] exp_wr_addr = 24'd0;

  sdram_fifo_ctrl #(.WR_END(24'd512)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .wr_fifo_wr_en(wr_fifo_wr_en), .wr_fifo_wr_data(wr_fifo_wr_data),
    .wr_fifo_full(wr_fifo_full), .rd_valid(rd_valid),
    .rd_fifo_rd_en(rd_fifo_rd_en), .rd_fifo_rd_data(rd_fifo_rd_data),
    .rd_fifo_empty(rd_fifo_empty), .sdram_wr_req(sdram_wr_req),
    .sdram_wr_ack(sdram_wr_ack), .sdram_wr_addr(sdram_wr_addr),
    .sdram_wr_data(sdram_wr_data), .wr_burst_len(wr_burst_len),
    .sdram_rd_req(sdram_rd_req), .sdram_rd_ack(sdram_rd_ack),
    .sdram_rd_addr(sdram_rd_addr), .sdram_rd_data(sdram_rd_data),
    .rd_burst_len(rd_burst_len)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      wr_fifo_wr_en   = 1'b1;
      wr_fifo_wr_data = 16'(base + i);
      if (wr_q.size() < 1024) wr_q.push_back(16'(base + i));
    end
    @(negedge sys_clk);
    wr_fifo_wr_en = 1'b0;
  endtask

  task automatic do_wr_burst();
    logic [15:0] exp;
    logic [23:0] nxt;
    bit          ok = 1'b0;
    for (int c = 0; c < 8 && !ok; c++) begin
      if (sdram_wr_req === 1'b1) ok = 1'b1;
      else @(negedge sys_clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wr_req_timeout: req=%b required 1", sdram_wr_req);
      return;
    end
    n_checks++;
    if (sdram_wr_addr !== exp_wr_addr) begin
      n_fail++;
      $display("FAIL wr_addr_start: got %0d required %0d", sdram_wr_addr, exp_wr_addr);
    end
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge sys_clk);
      sdram_wr_ack = 1'b1;
      exp = (wr_q.size() > 0) ? wr_q.pop_front() : 16'hxxxx;
      n_checks++;
      if (sdram_wr_data !== exp) begin
        n_fail++;
        $display("FAIL wr_data[%0d]: got %h required %h", i, sdram_wr_data, exp);
      end
      if (i == 1) begin
        n_checks++;
        if (sdram_wr_req !== 1'b0) begin
          n_fail++;
          $display("FAIL wr_req_drop: got %b required 0", sdram_wr_req);
        end
      end
      if (i == 128) begin
        n_checks++;
        if (sdram_wr_addr !== exp_wr_addr) begin
          n_fail++;
          $display("FAIL wr_addr_stable: got %0d required %0d", sdram_wr_addr, exp_wr_addr);
        end
      end
    end
    @(negedge sys_clk);
    sdram_wr_ack = 1'b0;
    @(negedge sys_clk);
    nxt = (exp_wr_addr + 24'd256 >= 24'd512) ? 24'd0 : exp_wr_addr + 24'd256;
    exp_wr_addr = nxt;
    n_checks++;
    if (sdram_wr_addr !== nxt || sdram_wr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_burst_end: addr=%0d req=%b required addr=%0d req=0",
               sdram_wr_addr, sdram_wr_req, nxt);
    end
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    n_checks++;
    if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0 || sdram_wr_addr !== 24'd0 ||
        sdram_rd_addr !== 24'd0 || wr_fifo_full !== 1'b0 || rd_fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: wreq=%b rreq=%b waddr=%0d raddr=%0d full=%b empty=%b required 0 0 0 0 0 1",
               sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr, wr_fifo_full, rd_fifo_empty);
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if (sdram_wr_data !== 16'd0 || rd_fifo_rd_data !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data: wr=%h rd=%h required 0 0", sdram_wr_data, rd_fifo_rd_data);
    end
    n_checks++;
    if (wr_burst_len !== 10'd256 || rd_burst_len !== 10'd256) begin
      n_fail++;
      $display("FAIL burst_len: wr=%0d rd=%0d required 256", wr_burst_len, rd_burst_len);
    end
  endtask

  task automatic test_threshold();
    init_end = 1'b1;
    push_words(255, 0);
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if (sdram_wr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_req_below_burst: got %b required 0", sdram_wr_req);
    end
    push_words(1, 255);
  endtask

  task automatic test_write_burst();
    do_wr_burst();
  endtask

  task automatic test_write_wrap();
    push_words(256, 256);
    do_wr_burst();
    n_checks++;
    if (sdram_wr_addr !== 24'd0) begin
      n_fail++;
      $display("FAIL wr_wrap: got %0d required 0", sdram_wr_addr);
    end
  endtask

  task automatic test_priority();
    bit ok = 1'b0;
    push_words(256, 512);
    rd_valid = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if (sdram_wr_req !== 1'b1 || sdram_rd_req !== 1'b0) begin
      n_fail++;
      $display("FAIL priority: wreq=%b rreq=%b required 1 0", sdram_wr_req, sdram_rd_req);
    end
    do_wr_burst();
    for (int c = 0; c < 8 && !ok; c++) begin
      if (sdram_rd_req === 1'b1) ok = 1'b1;
      else @(negedge sys_clk);
    end
    n_checks++;
    if (!ok || sdram_rd_addr !== 24'd0) begin
      n_fail++;
      $display("FAIL rd_req_after_wr: req=%b addr=%0d required 1 0", sdram_rd_req, sdram_rd_addr);
    end
  endtask

  task automatic test_read_and_flush();
    logic [15:0] exp;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge sys_clk);
      rd_fifo_rd_en = 1'b0;
      if (i > 0) begin
        exp = (rd_q.size() > 0) ? rd_q.pop_front() : 16'hxxxx;
        n_checks++;
        if (rd_fifo_empty !== 1'b0 || rd_fifo_rd_data !== exp) begin
          n_fail++;
          $display("FAIL rd_data[%0d]: empty=%b data=%h required 0 %h", i, rd_fifo_empty, rd_fifo_rd_data, exp);
        end
        rd_fifo_rd_en = 1'b1;
      end
      if (i == 1) begin
        n_checks++;
        if (sdram_rd_req !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_req_drop: got %b required 0", sdram_rd_req);
        end
      end
      sdram_rd_ack  = 1'b1;
      sdram_rd_data = 16'h1000 + 16'(i);
      rd_q.push_back(16'h1000 + 16'(i));
    end
    @(negedge sys_clk);
    sdram_rd_ack  = 1'b0;
    rd_fifo_rd_en = 1'b0;
    rd_valid      = 1'b0;
    @(negedge sys_clk);
    exp = (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx;
    n_checks++;
    if (rd_fifo_empty !== 1'b0 || rd_fifo_rd_data !== exp || sdram_rd_addr !== 24'd256 ||
        sdram_rd_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_burst_end: empty=%b data=%h addr=%0d req=%b required 0 %h 256 0",
               rd_fifo_empty, rd_fifo_rd_data, sdram_rd_addr, sdram_rd_req, exp);
    end
    @(negedge sys_clk);
    rd_q.delete();
    n_checks++;
    if (rd_fifo_empty !== 1'b1 || sdram_rd_addr !== 24'd0) begin
      n_fail++;
      $display("FAIL rd_flush: empty=%b addr=%0d required 1 0", rd_fifo_empty, sdram_rd_addr);
    end
  endtask

  task automatic test_full();
    push_words(1025, 16'h2000);
    n_checks++;
    if (wr_fifo_full !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_full: got %b required 1", wr_fifo_full);
    end
    repeat (4) do_wr_burst();
    n_checks++;
    if (wr_fifo_full !== 1'b0 || sdram_wr_data !== 16'd0 || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL wr_drained: full=%b data=%h left=%0d required 0 0 0",
               wr_fifo_full, sdram_wr_data, wr_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    push_words(256, 16'h3000);
    repeat (3) @(negedge sys_clk);
    sdram_wr_ack = 1'b1;
    repeat (10) @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    n_checks++;
    if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0 || sdram_wr_addr !== 24'd0 ||
        sdram_rd_addr !== 24'd0 || wr_fifo_full !== 1'b0 || rd_fifo_empty !== 1'b1 ||
        sdram_wr_data !== 16'd0 || rd_fifo_rd_data !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: wreq=%b rreq=%b waddr=%0d raddr=%0d full=%b empty=%b wd=%h rd=%h required reset values",
               sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr, wr_fifo_full,
               rd_fifo_empty, sdram_wr_data, rd_fifo_rd_data);
    end
    sdram_wr_ack = 1'b0;
    wr_q.delete();
    exp_wr_addr = 24'd0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_write_burst();
    test_write_wrap();
    test_priority();
    test_read_and_flush();
    test_full();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
